// File: rtl/display_plane_writer.sv
// Framebuffer write-address generator: turns the PPU pixel stream into linear RAM writes
// and rotates write/display buffers. Optional macro: DISPLAY_PLANE_OVERSCAN_CROP_EN.
module display_plane_writer #(
    parameter int unsigned H_ACTIVE = 256,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned NUM_BUFS = 2,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic              ppu_clock,
    input  logic              rst_n,
    input  logic              rendering,
    input  logic              frame_start,
    output logic [ADDR_W-1:0] addr,
    output logic              wr,
    output logic [8:0]        x,
    output logic [7:0]        y,
    output logic [1:0]        wr_buf,
    output logic [1:0]        display_buf,
    output logic              frame_done,
    output logic              overrun
);

`ifdef DISPLAY_PLANE_OVERSCAN_CROP_EN
    localparam int unsigned FRAME_SIZE = H_ACTIVE * (V_ACTIVE - 16);
`else
    localparam int unsigned FRAME_SIZE = H_ACTIVE * V_ACTIVE;
`endif

    typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

    state_e            state_q, state_d;
    logic [8:0]        col_q;
    logic [7:0]        row_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] base_q;
    logic              accept;
    logic              col_wrap;
    logic              last_pix;
    logic              visible;

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        col_wrap = (col_q == 9'(H_ACTIVE - 1));
        last_pix = col_wrap && (row_q == 8'(V_ACTIVE - 1));
`ifdef DISPLAY_PLANE_OVERSCAN_CROP_EN
        visible  = (row_q >= 8'd8) && (row_q < 8'(V_ACTIVE - 8));
`else
        visible  = 1'b1;
`endif
        if (frame_start) begin
            state_d = StActive;
        end else if (state_q == StActive && rendering) begin
            accept = 1'b1;
            if (last_pix) begin
                state_d = StDone;
            end
        end
    end

    always_ff @(posedge ppu_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            idx_q       <= '0;
            base_q      <= '0;
            addr        <= '0;
            wr          <= 1'b0;
            x           <= '0;
            y           <= '0;
            wr_buf      <= '0;
            display_buf <= 2'(NUM_BUFS - 1);
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr         <= 1'b0;
            frame_done <= 1'b0;
            if (frame_start) begin
                // The pixel coinciding with frame_start is dropped.
                col_q <= '0;
                row_q <= '0;
                idx_q <= '0;
                if (state_q == StDone) begin
                    if (wr_buf == 2'(NUM_BUFS - 1)) begin
                        wr_buf <= '0;
                        base_q <= '0;
                    end else begin
                        wr_buf <= wr_buf + 2'd1;
                        base_q <= base_q + ADDR_W'(FRAME_SIZE);
                    end
                end else if (state_q == StActive) begin
                    overrun <= 1'b1;
                end
            end else if (accept) begin
                if (visible) begin
                    wr    <= 1'b1;
                    addr  <= base_q + idx_q;
                    x     <= col_q;
                    y     <= row_q;
                    idx_q <= idx_q + 1'b1;
                end
                if (col_wrap) begin
                    col_q <= '0;
                    row_q <= row_q + 8'd1;
                end else begin
                    col_q <= col_q + 9'd1;
                end
                if (last_pix) begin
                    frame_done  <= 1'b1;
                    display_buf <= wr_buf;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_plane_writer.sv
// Scoreboard bench for display_plane_writer on a reduced raster so every scenario runs
// several full frames in a few thousand cycles.
module tb_display_plane_writer;

    localparam int unsigned H  = 16;
    localparam int unsigned V  = 20;
    localparam int unsigned NB = 2;
    localparam int unsigned AW = 10;
`ifdef DISPLAY_PLANE_OVERSCAN_CROP_EN
    localparam bit CROP = 1'b1;
    localparam int FRAME = H * (V - 16);
`else
    localparam bit CROP = 1'b0;
    localparam int FRAME = H * V;
`endif

    typedef struct {
        bit vis;
        bit done;
        int a;
        int cx;
        int cy;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rendering = 1'b0;
    logic          frame_start = 1'b0;
    logic [AW-1:0] addr;
    logic          wr;
    logic [8:0]    x;
    logic [7:0]    y;
    logic [1:0]    wr_buf;
    logic [1:0]    display_buf;
    logic          frame_done;
    logic          overrun;

    int   n_total = 0;
    int   n_bad = 0;
    exp_t q[$];

    // model state: 0 idle, 1 active, 2 done
    int m_state, m_col, m_row, m_idx, m_buf, m_disp, m_last_addr;
    bit m_ovr;

    display_plane_writer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .NUM_BUFS (NB),
        .ADDR_W   (AW)
    ) dut (
        .ppu_clock   (clk),
        .rst_n       (rst_n),
        .rendering   (rendering),
        .frame_start (frame_start),
        .addr        (addr),
        .wr          (wr),
        .x           (x),
        .y           (y),
        .wr_buf      (wr_buf),
        .display_buf (display_buf),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_col = 0; m_row = 0; m_idx = 0; m_buf = 0;
        m_disp = NB - 1; m_ovr = 1'b0; m_last_addr = 0;
        q.delete();
    endtask

    // Drive one cycle of stimulus, predicting what the DUT will emit after the edge.
    task automatic step(input bit r, input bit fs);
        exp_t e;
        bit   vis, last;
        rendering   = r;
        frame_start = fs;
        if (fs) begin
            if (m_state == 2) m_buf = (m_buf + 1) % NB;
            else if (m_state == 1) m_ovr = 1'b1;
            m_col = 0; m_row = 0; m_idx = 0; m_state = 1;
        end else if (m_state == 1 && r) begin
            vis  = !CROP || (m_row >= 8 && m_row < int'(V) - 8);
            last = (m_col == int'(H) - 1) && (m_row == int'(V) - 1);
            e.vis = vis; e.done = last;
            e.a = m_buf * FRAME + m_idx; e.cx = m_col; e.cy = m_row;
            if (vis || last) q.push_back(e);
            if (vis) begin
                m_last_addr = e.a;
                m_idx++;
            end
            m_col++;
            if (m_col == int'(H)) begin
                m_col = 0;
                m_row++;
            end
            if (last) begin
                m_disp = m_buf;
                m_state = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (wr || frame_done)) begin
            if (q.size() == 0) begin
                check("unexpected_wr", int'(wr), 0);
                check("unexpected_done", int'(frame_done), 0);
            end else begin
                e = q.pop_front();
                check("wr", int'(wr), int'(e.vis));
                check("frame_done", int'(frame_done), int'(e.done));
                if (e.vis) begin
                    check("addr", int'(addr), e.a);
                    check("x", int'(x), e.cx);
                    check("y", int'(y), e.cy);
                end
            end
        end
    end

    task automatic check_status(input string tag);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check({tag, "_drained"}, q.size(), 0);
        check({tag, "_wr_buf"}, int'(wr_buf), m_buf);
        check({tag, "_display_buf"}, int'(display_buf), m_disp);
        check({tag, "_overrun"}, int'(overrun), int'(m_ovr));
    endtask

    task automatic run_frame(input bit gated);
        step(1'b0, 1'b1);
        for (int i = 0; i < int'(H * V); i++) begin
            if (gated) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"}, int'(addr), 0);
        check({tag, "_wr"}, int'(wr), 0);
        check({tag, "_x"}, int'(x), 0);
        check({tag, "_y"}, int'(y), 0);
        check({tag, "_wr_buf"}, int'(wr_buf), 0);
        check({tag, "_display_buf"}, int'(display_buf), NB - 1);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_values("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_frame(1'b0);
        check_status("frame1");
        check("frame1_last_addr", int'(addr), FRAME - 1);

        // Rendering after completion must not write or move addr.
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
        check("done_addr_hold", int'(addr), m_last_addr);
        check("done_wr_low", int'(wr), 0);

        run_frame(1'b0);
        check_status("frame2");
        run_frame(1'b1);
        check_status("frame3_gated");

        // Cut the frame short, then finish a good one; overrun must persist.
        step(1'b0, 1'b1);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_status("overrun_cut");
        for (int i = 0; i < int'(H * V); i++) step(1'b1, 1'b0);
        check_status("overrun_good");

        // Asynchronous reset in the middle of a frame.
        step(1'b0, 1'b1);
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        model_reset();
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b1);
        for (int i = 0; i < int'(H * V); i++) step(1'b1, 1'b0);
        check_status("after_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/display_plane_writer.md
Name: display_plane_writer

Overview:
- Parametrised framebuffer write-address generator for the PPU-to-VGA path.
- Counts active PPU pixels into a linear framebuffer that is NUM_BUFS frames deep, rotating write/display buffers at frame boundaries.
- Tracks raster x/y and flags frames that were cut short.
- Sits between the PPU pixel stream (rendering/frame_start) and the dual-port framebuffer RAM; the VGA scan-out reads from display_buf.

Parameters:
- H_ACTIVE, 256, active pixels per line.
- V_ACTIVE, 240, active lines per frame.
- NUM_BUFS, 2, number of frame buffers (1..4).
- ADDR_W, 17, framebuffer address width; must satisfy 2^ADDR_W >= NUM_BUFS*H_ACTIVE*V_ACTIVE.

Ports:
- ppu_clock  in  1  PPU pixel clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rendering  in  1  a visible pixel is produced this cycle.
- frame_start  in  1  single-cycle pulse marking the start of a PPU frame.
- addr  out  ADDR_W  framebuffer write address.
- wr  out  1  framebuffer write enable.
- x  out  9  column of the pixel being written.
- y  out  8  row of the pixel being written.
- wr_buf  out  2  buffer index currently being written.
- display_buf  out  2  most recently completed buffer, for scan-out.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is written.
- overrun  out  1  sticky flag: frame_start arrived before the frame completed.

Behaviour:
- Reset, asynchronous: addr=0, wr=0, x=0, y=0, wr_buf=0, display_buf=NUM_BUFS-1 (or 0 when NUM_BUFS=1), frame_done=0, overrun=0, state=IDLE.
- States:
  - IDLE: waits for frame_start.
  - ACTIVE: accepts pixels.
  - DONE: frame complete; ignores rendering.
- All outputs are registered. A pixel accepted at edge N drives addr/wr/x/y during cycle N+1, i.e. one-cycle latency. The pixel data path delays by one cycle to match.
- ACTIVE with rendering=1:
  - wr<=1; addr<=base+idx, where base=wr_buf*H_ACTIVE*V_ACTIVE and idx is the linear pixel count.
  - Use a running base register and an incrementing counter; no multiplier.
  - x<=col and y<=row of that pixel; col/row then advance, with col wrapping at H_ACTIVE-1 and incrementing row.
- ACTIVE with rendering=0: wr<=0; addr, x and y hold.
- Last pixel (col=H_ACTIVE-1, row=V_ACTIVE-1) accepted:
  - frame_done pulses with that write.
  - display_buf<=wr_buf; state->DONE.
- DONE with rendering=1: wr stays 0; no address advance; no error.
- frame_start in any state:
  - Internal col/row/idx clear; wr<=0 that cycle, even if rendering=1, so that pixel is dropped; state->ACTIVE.
  - If the previous state was DONE, wr_buf<=(wr_buf+1) mod NUM_BUFS. The buffer currently shown as display_buf is never selected for writing when NUM_BUFS>=2.
  - If the previous state was ACTIVE (frame incomplete): overrun<=1 and wr_buf is unchanged, so the same buffer is rewritten from 0.
- frame_start while in IDLE: first frame, wr_buf stays 0.
- overrun clears only on reset.
- NUM_BUFS=1: wr_buf and display_buf are always 0; tearing is accepted.
- Asynchronous reset mid-frame aborts immediately; the next frame_start restarts at buffer 0.
- addr never exceeds NUM_BUFS*H_ACTIVE*V_ACTIVE-1.

Optional Feature:
- Macro: DISPLAY_PLANE_OVERSCAN_CROP_EN.
- When defined:
  - Rows 0-7 and V_ACTIVE-8..V_ACTIVE-1 are counted (row/col advance) but wr stays 0 and idx does not advance.
  - Frame size becomes H_ACTIVE*(V_ACTIVE-16). Buffer bases use this reduced size.
  - y reports the raster row (8..V_ACTIVE-9) for written pixels.
  - frame_done still fires on the last raster pixel.
- When undefined: every active pixel is written, as described above.

Test Plan:
- Reset, frame_start, then 61440 rendering cycles (defaults) -> wr high 61440 cycles, addr 0..0xEFFF, last write x=255 y=239, frame_done one pulse, display_buf=0.
- Second complete frame -> wr_buf=1, addr 0xF000..0x1DFFF, display_buf=1 at end; third frame -> wr_buf=0 again, addr starts at 0.
- Rendering gated 1-on/1-off for a frame -> addr increments only on wr cycles, x/y sequence unbroken, 122880 cycles total.
- frame_start after 1000 pixels -> overrun=1, wr_buf unchanged, next write addr=base+0, x=0 y=0; overrun persists through later good frames.
- Extra 50 rendering cycles after frame_done -> wr stays 0, addr holds at last value; assert rst_n low mid-frame -> all outputs immediately reset values.
- With DISPLAY_PLANE_OVERSCAN_CROP_EN -> first write at y=8 x=0 addr=0, 57344 writes per frame, second frame base=0xE000.
